// File: rtl/sram_port_arbiter.sv
// Arbiter that lets the fetch (inst) and load/store (data) requesters share one
// single-port synchronous SRAM. Data wins by default; a starvation counter forces an inst grant.
module sram_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int SCNT_W     = 3
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [3:0]        data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,

   output logic              sram_en,
   output logic [3:0]        sram_wen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_INST,
      OWN_DATA
   } owner_t;

   localparam logic [SCNT_W-1:0] CNT_MAX = SCNT_W'(STARVE_MAX);

   logic [SCNT_W-1:0] starve_cnt, starve_cnt_next;
   owner_t            resp_owner, resp_owner_next;
   logic              force_inst, grant_inst, grant_data;

   // Grants are suppressed while reset is held so nothing reaches the SRAM.
   always_comb begin
      force_inst = inst_req && (starve_cnt == CNT_MAX);
      grant_inst = !reset && inst_req && (!data_req || force_inst);
      grant_data = !reset && data_req && !grant_inst;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      inst_addr_ok = grant_inst;
      data_addr_ok = grant_data;
      sram_en      = grant_inst | grant_data;
      sram_wen     = 4'b0000;
      sram_addr    = '0;
      sram_wdata   = data_wdata;
      if (grant_inst) begin
         sram_addr = inst_addr;
      end else if (grant_data) begin
         sram_addr = data_addr;
         if (data_wr) sram_wen = data_wstrb;
      end
   end

   always_comb begin
      starve_cnt_next = starve_cnt;
      if (grant_inst || !inst_req) begin
         starve_cnt_next = '0;
      end else if (grant_data && (starve_cnt != CNT_MAX)) begin
         starve_cnt_next = starve_cnt + SCNT_W'(1);
      end

      resp_owner_next = OWN_NONE;
      if (grant_inst)      resp_owner_next = OWN_INST;
      else if (grant_data) resp_owner_next = OWN_DATA;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
         resp_owner <= OWN_NONE;
      end else begin
         starve_cnt <= starve_cnt_next;
         resp_owner <= resp_owner_next;
      end
   end

   // A response in flight when reset rises is dropped in that same cycle.
   always_comb begin
      inst_data_ok = !reset && (resp_owner == OWN_INST);
      data_data_ok = !reset && (resp_owner == OWN_DATA);
      inst_rdata   = sram_rdata;
      data_rdata   = sram_rdata;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the fetch requester (inst) and the load/store requester (data, driven from EXE).
- At most one request is granted per cycle, using combinational addr_ok.
- Data requests win by default. A starvation counter forces one inst grant after STARVE_MAX consecutive data wins while inst waits.
- Responses come back one cycle after grant (data_ok + rdata), routed by a registered owner tag.

Parameters:
- ADDR_W, 32, address width for both requesters and the SRAM.
- STARVE_MAX, 4, consecutive data grants tolerated while inst_req is pending; legal range 1..7.
- SCNT_W, 3, starvation counter width; must hold STARVE_MAX.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  in  1  fetch read request
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request granted this cycle
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request granted this cycle
- data_data_ok  out  1  data response valid (loads and stores)
- data_rdata  out  32  load data
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid one cycle after sram_en

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Reset state:
  - starve_cnt = 0; resp_owner = NONE.
  - Both data_ok outputs are 0 in the reset cycle and the cycle after.
  - addr_ok outputs and sram_en are 0 while reset is high.
- Grant logic (combinational, same cycle):
  - force_inst = inst_req && (starve_cnt == STARVE_MAX).
  - grant_inst = inst_req && (!data_req || force_inst).
  - grant_data = data_req && !grant_inst.
  - inst_addr_ok = grant_inst; data_addr_ok = grant_data. The two are mutually exclusive.
- SRAM drive:
  - sram_en = grant_inst | grant_data.
  - sram_addr is the winner's address; it is 0 when idle.
  - sram_wen = data_wstrb when grant_data && data_wr, otherwise 4'b0000. Inst is always a read.
  - sram_wdata = data_wdata; don't-care when the request is not a store.
- Starvation counter (registered):
  - grant_data && inst_req: starve_cnt increments, saturating at STARVE_MAX.
  - grant_inst or !inst_req: starve_cnt clears to 0.
- Response tracking (registered): resp_owner <= INST / DATA / NONE according to the grant in the current cycle.
- Response outputs:
  - inst_data_ok = (resp_owner == INST); data_data_ok = (resp_owner == DATA).
  - rdata for both requesters = sram_rdata, passed straight through.
  - Latency is exactly 1 cycle from addr_ok to data_ok.
  - No backpressure: requesters must accept data_ok when it is asserted.
- Throughput: back-to-back grants are allowed every cycle, and a response and a new grant coexist in the same cycle.
- Store semantics: a store still produces data_data_ok one cycle later; data_rdata carries no meaning for stores.
- A store with data_wstrb = 0 is granted, writes no bytes, and still returns data_data_ok.
- Requests not granted are held by the requester; the arbiter keeps no request state.
- Reset asserted while a response is in flight: the response is dropped, no data_ok follows, and starve_cnt clears.

Test Plan:
- Reset, then inst_req=1 at addr 0x1c000000 for 1 cycle with data_req=0 → inst_addr_ok=1, sram_en=1, sram_wen=0; next cycle inst_data_ok=1 and inst_rdata = SRAM word.
- Simultaneous inst_req and data_req (load, 0x100) → data_addr_ok=1, inst_addr_ok=0; next cycle data_data_ok=1 and inst_data_ok=0.
- data_req and inst_req held high continuously, STARVE_MAX=4 → grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt reads 4 in the cycle of each inst grant.
- Store sb to 0x203 (wr=1, wstrb=4'b1000, wdata=0xAB000000) → sram_wen=4'b1000, sram_addr=0x203; next cycle data_data_ok=1; a following load of 0x200 returns byte[31:24]=0xAB.
- Alternating grants every cycle (I,D,I,D) → data_ok alternates inst/data one cycle behind, with no bubble and no double assertion.
- Grant a load, then assert reset the next cycle → data_data_ok=0 in that cycle and the one after; after reset deasserts, the first grant behaves as in scenario 1.
